// File: rtl/audio_dac_serializer.sv
// I2S transmitter for the WM8731 DAC path. It buffers stereo pairs and shifts them out MSB-first.
// The block is slaved to the codec-driven BCLK and DACLRCK.
module audio_dac_serializer #(
   parameter int DATA_WIDTH = 24,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic [DATA_WIDTH-1:0]              left_data,
   input  logic [DATA_WIDTH-1:0]              right_data,
   input  logic                               in_valid,
   output logic                               in_ready,
   input  logic                               aud_bclk,
   input  logic                               aud_daclrck,
   output logic                               aud_dacdat,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level,
   output logic                               underflow,
   input  logic                               clear_underflow
);

   localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = $clog2(DATA_WIDTH + 1);
   localparam logic [LVL_W-1:0] DEPTH_LVL = LVL_W'(FIFO_DEPTH);
   localparam logic [CNT_W-1:0] WORD_BITS = CNT_W'(DATA_WIDTH);

   typedef enum logic [1:0] {SYNC, LEFT, RIGHT} state_t;

   logic [1:0]                  bclkSync_q;
   logic                        bclkDly_q;
   logic [1:0]                  lrSync_q;
   logic                        bclkFall;
   logic                        lrNow;
   logic                        frameStart;
   logic                        rightStart;

   logic [2*DATA_WIDTH-1:0]     mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]            wrPtr_q, rdPtr_q;
   logic [LVL_W-1:0]            count_q;
   logic                        fifoEmpty, fifoFull, fifoPush, fifoPop;
   logic [2*DATA_WIDTH-1:0]     fifoRdData;

   state_t                      state_q, state_d;
   logic [DATA_WIDTH-1:0]       shift_q, shift_d;
   logic [DATA_WIDTH-1:0]       hold_q, hold_d;
   logic [CNT_W-1:0]            bitCnt_q, bitCnt_d;
   logic                        dac_q, dac_d;
   logic                        lrPrev_q, lrPrev_d;
   logic                        underflow_q, underflow_d;
   logic                        popReq;

   // Both codec clocks share the same two-stage depth so an LRCK change that coincides
   // with a BCLK fall is seen on that very fall event.
   always_ff @(posedge clk) begin
      if (reset) begin
         bclkSync_q <= '0;
         bclkDly_q  <= 1'b0;
         lrSync_q   <= '0;
      end else begin
         bclkSync_q <= {bclkSync_q[0], aud_bclk};
         bclkDly_q  <= bclkSync_q[1];
         lrSync_q   <= {lrSync_q[0], aud_daclrck};
      end
   end

   assign bclkFall   = bclkDly_q & ~bclkSync_q[1];
   assign lrNow      = lrSync_q[1];
   assign frameStart = bclkFall & lrPrev_q & ~lrNow;
   assign rightStart = bclkFall & ~lrPrev_q & lrNow;

   assign fifoEmpty  = (count_q == '0);
   assign fifoFull   = (count_q == DEPTH_LVL);
   assign fifoPush   = in_valid & ~fifoFull;
   assign fifoPop    = popReq & ~fifoEmpty;
   assign fifoRdData = mem_q[rdPtr_q];

   always_ff @(posedge clk) begin
      if (fifoPush) mem_q[wrPtr_q] <= {left_data, right_data};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
      end else begin
         if (fifoPush) wrPtr_q <= wrPtr_q + PTR_W'(1);
         if (fifoPop)  rdPtr_q <= rdPtr_q + PTR_W'(1);
         case ({fifoPush, fifoPop})
            2'b10:   count_q <= count_q + LVL_W'(1);
            2'b01:   count_q <= count_q - LVL_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // A frame start always reloads both channel words, even from LEFT/RIGHT. This lets a
   // short channel truncate cleanly instead of waiting for the full word.
   always_comb begin
      state_d     = state_q;
      shift_d     = shift_q;
      hold_d      = hold_q;
      bitCnt_d    = bitCnt_q;
      dac_d       = dac_q;
      lrPrev_d    = lrPrev_q;
      underflow_d = underflow_q;
      popReq      = 1'b0;

      if (bclkFall) lrPrev_d = lrNow;

      case (state_q)
         SYNC: begin
            dac_d = 1'b0;
            if (frameStart) begin
               state_d = LEFT;
               popReq  = 1'b1;
            end
         end
         LEFT, RIGHT: begin
            if (frameStart) begin
               state_d = LEFT;
               popReq  = 1'b1;
               dac_d   = 1'b0;
            end else if (rightStart) begin
               state_d  = RIGHT;
               shift_d  = hold_q;
               bitCnt_d = '0;
               dac_d    = 1'b0;
            end else if (bclkFall) begin
               if (bitCnt_q < WORD_BITS) begin
                  dac_d    = shift_q[DATA_WIDTH-1];
                  shift_d  = {shift_q[DATA_WIDTH-2:0], 1'b0};
                  bitCnt_d = bitCnt_q + CNT_W'(1);
               end else begin
                  dac_d = 1'b0;
               end
            end
         end
         default: state_d = SYNC;
      endcase

      if (popReq) begin
         bitCnt_d = '0;
         if (fifoEmpty) begin
            shift_d = '0;
            hold_d  = '0;
         end else begin
            shift_d = fifoRdData[2*DATA_WIDTH-1:DATA_WIDTH];
            hold_d  = fifoRdData[DATA_WIDTH-1:0];
         end
      end

      if (clear_underflow) underflow_d = 1'b0;
      if (popReq && fifoEmpty) underflow_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= SYNC;
         shift_q     <= '0;
         hold_q      <= '0;
         bitCnt_q    <= '0;
         dac_q       <= 1'b0;
         lrPrev_q    <= 1'b1;
         underflow_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         shift_q     <= shift_d;
         hold_q      <= hold_d;
         bitCnt_q    <= bitCnt_d;
         dac_q       <= dac_d;
         lrPrev_q    <= lrPrev_d;
         underflow_q <= underflow_d;
      end
   end

   assign in_ready   = ~fifoFull;
   assign aud_dacdat = dac_q;
   assign fifo_level = count_q;
   assign underflow  = underflow_q;

endmodule

// File: tb/tb_audio_dac_serializer.sv
// Bench for audio_dac_serializer. It plays the codec, generating BCLK/LRCK and deserialising
// DACDAT on the BCLK rising edge. Received pairs are checked against a scoreboard of pushed pairs.
module tb_audio_dac_serializer;

   localparam int DW    = 24;
   localparam int DEPTH = 8;
   localparam int LW    = $clog2(DEPTH + 1);
   localparam int HALF  = 8;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic [DW-1:0] leftData = '0;
   logic [DW-1:0] rightData = '0;
   logic          inValid = 1'b0;
   logic          inReady;
   logic          bclk = 1'b1;
   logic          lrck = 1'b1;
   logic          dacdat;
   logic [LW-1:0] fifoLevel;
   logic          underflow;
   logic          clearUnderflow = 1'b0;

   int            errors = 0;
   int            checks = 0;
   logic [2*DW-1:0] expQ[$];
   logic          modelUnder = 1'b0;

   audio_dac_serializer #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk),
      .reset(reset),
      .left_data(leftData),
      .right_data(rightData),
      .in_valid(inValid),
      .in_ready(inReady),
      .aud_bclk(bclk),
      .aud_daclrck(lrck),
      .aud_dacdat(dacdat),
      .fifo_level(fifoLevel),
      .underflow(underflow),
      .clear_underflow(clearUnderflow)
   );

   always #10 clk = ~clk;

   task automatic applyReset();
      @(negedge clk);
      reset = 1'b1; bclk = 1'b1; lrck = 1'b1; inValid = 1'b0; clearUnderflow = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      expQ.delete();
      modelUnder = 1'b0;
   endtask

   task automatic pushPair(input logic [DW-1:0] l, input logic [DW-1:0] r);
      logic expAccept;
      @(negedge clk);
      expAccept = (expQ.size() < DEPTH);
      checks++;
      if (inReady !== expAccept) begin
         errors++;
         $display("[TB] FAIL push_in_ready: got %0b want %0b", inReady, expAccept);
      end
      leftData = l; rightData = r; inValid = 1'b1;
      @(negedge clk);
      inValid = 1'b0;
      if (expAccept) expQ.push_back({l, r});
      checks++;
      if (fifoLevel !== LW'(expQ.size())) begin
         errors++;
         $display("[TB] FAIL push_level: got %0d want %0d", fifoLevel, expQ.size());
      end
   endtask

   // Right-channel BCLK cycles only, so no frame can start.
   task automatic runIdle(input int nBits);
      logic bad = 1'b0;
      for (int k = 0; k < nBits; k++) begin
         @(negedge clk);
         bclk = 1'b0; lrck = 1'b1;
         repeat (HALF) @(negedge clk);
         if (dacdat !== 1'b0) bad = 1'b1;
         bclk = 1'b1;
         repeat (HALF - 1) @(negedge clk);
      end
      checks++;
      if (bad !== 1'b0) begin
         errors++;
         $display("[TB] FAIL idle_dacdat: got nonzero want 0");
      end
      checks++;
      if (fifoLevel !== LW'(expQ.size())) begin
         errors++;
         $display("[TB] FAIL idle_level: got %0d want %0d", fifoLevel, expQ.size());
      end
   endtask

   // One stereo frame of nBits BCLKs per channel; abortBit >= 0 pulses reset at that left-slot fall.
   task automatic runFrame(input int nBits, input int abortBit);
      logic [2*DW-1:0] expPair;
      logic [DW-1:0]   gotL = '0;
      logic [DW-1:0]   gotR = '0;
      logic [DW-1:0]   mask = '0;
      logic            extraNz = 1'b0;
      logic            lat2 = 1'b0;
      logic            lat3 = 1'b0;
      logic            b;
      int              dataBits;
      if (expQ.size() > 0) expPair = expQ.pop_front();
      else begin
         expPair = '0;
         modelUnder = 1'b1;
      end
      dataBits = (nBits - 1 < DW) ? nBits - 1 : DW;
      for (int i = 0; i < DW; i++) if (i >= DW - dataBits) mask[i] = 1'b1;

      for (int ch = 0; ch < 2; ch++) begin
         for (int k = 0; k < nBits; k++) begin
            @(negedge clk);
            bclk = 1'b0;
            if (k == 0) lrck = (ch == 1);
            if (ch == 0 && k == abortBit) begin
               repeat (4) @(negedge clk);
               reset = 1'b1;
               @(negedge clk);
               reset = 1'b0;
               checks++;
               if (dacdat !== 1'b0) begin
                  errors++;
                  $display("[TB] FAIL abort_dacdat: got %0b want 0", dacdat);
               end
               checks++;
               if (fifoLevel !== '0) begin
                  errors++;
                  $display("[TB] FAIL abort_level: got %0d want 0", fifoLevel);
               end
               bclk = 1'b1; lrck = 1'b1;
               expQ.delete();
               modelUnder = 1'b0;
               return;
            end
            if (ch == 0 && k == 1) begin
               repeat (2) @(negedge clk);
               lat2 = dacdat;
               @(negedge clk);
               lat3 = dacdat;
               repeat (HALF - 3) @(negedge clk);
            end else begin
               repeat (HALF) @(negedge clk);
            end
            b = dacdat;
            bclk = 1'b1;
            if (k >= 1 && k <= DW) begin
               if (ch == 0) gotL[DW-k] = b;
               else         gotR[DW-k] = b;
            end else if (b !== 1'b0) begin
               extraNz = 1'b1;
            end
            repeat (HALF - 1) @(negedge clk);
         end
      end

      checks++;
      if (gotL !== (expPair[2*DW-1:DW] & mask)) begin
         errors++;
         $display("[TB] FAIL frame_left: got %h want %h", gotL, expPair[2*DW-1:DW] & mask);
      end
      checks++;
      if (gotR !== (expPair[DW-1:0] & mask)) begin
         errors++;
         $display("[TB] FAIL frame_right: got %h want %h", gotR, expPair[DW-1:0] & mask);
      end
      checks++;
      if (extraNz !== 1'b0) begin
         errors++;
         $display("[TB] FAIL frame_pad_zero: got nonzero in slot/pad bits want 0");
      end
      checks++;
      if (lat2 !== 1'b0 || lat3 !== expPair[2*DW-1]) begin
         errors++;
         $display("[TB] FAIL frame_latency: got %0b%0b want 0%0b", lat2, lat3, expPair[2*DW-1]);
      end
      checks++;
      if (underflow !== modelUnder) begin
         errors++;
         $display("[TB] FAIL frame_underflow: got %0b want %0b", underflow, modelUnder);
      end
   endtask

   task automatic test_reset();
      applyReset();
      checks++;
      if (inReady !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %0b want 1", inReady); end
      checks++;
      if (dacdat !== 1'b0) begin errors++; $display("[TB] FAIL reset_dacdat: got %0b want 0", dacdat); end
      checks++;
      if (fifoLevel !== '0) begin errors++; $display("[TB] FAIL reset_level: got %0d want 0", fifoLevel); end
      checks++;
      if (underflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_underflow: got %0b want 0", underflow); end
   endtask

   task automatic test_basic();
      pushPair(24'hA5A5A5, 24'h123456);
      runFrame(32, -1);
   endtask

   task automatic test_underflow();
      runFrame(32, -1);
      @(negedge clk);
      clearUnderflow = 1'b1;
      @(negedge clk);
      clearUnderflow = 1'b0;
      modelUnder = 1'b0;
      checks++;
      if (underflow !== 1'b0) begin errors++; $display("[TB] FAIL underflow_clear: got %0b want 0", underflow); end
      runFrame(32, -1);
   endtask

   task automatic test_back_to_back();
      logic expAccept;
      applyReset();
      @(negedge clk);
      for (int i = 0; i < DEPTH + 1; i++) begin
         expAccept = (expQ.size() < DEPTH);
         checks++;
         if (inReady !== expAccept) begin
            errors++;
            $display("[TB] FAIL b2b_in_ready[%0d]: got %0b want %0b", i, inReady, expAccept);
         end
         leftData = DW'($urandom);
         rightData = DW'($urandom);
         inValid = 1'b1;
         @(negedge clk);
         if (expAccept) expQ.push_back({leftData, rightData});
         checks++;
         if (fifoLevel !== LW'(expQ.size())) begin
            errors++;
            $display("[TB] FAIL b2b_level[%0d]: got %0d want %0d", i, fifoLevel, expQ.size());
         end
      end
      inValid = 1'b0;
      checks++;
      if (inReady !== 1'b0) begin errors++; $display("[TB] FAIL b2b_full_ready: got %0b want 0", inReady); end
      runFrame(32, -1);
      checks++;
      if (fifoLevel !== LW'(DEPTH - 1)) begin errors++; $display("[TB] FAIL b2b_after_level: got %0d want %0d", fifoLevel, DEPTH - 1); end
      checks++;
      if (inReady !== 1'b1) begin errors++; $display("[TB] FAIL b2b_after_ready: got %0b want 1", inReady); end
   endtask

   task automatic test_lrck_high_start();
      applyReset();
      pushPair(24'h5A5A5A, 24'h0F0F0F);
      pushPair(24'h800001, 24'h7FFFFE);
      runIdle(40);
      runFrame(32, -1);
      runFrame(32, -1);
   endtask

   task automatic test_reset_midframe();
      applyReset();
      pushPair(24'hFFFFFF, 24'hFFFFFF);
      runFrame(32, 10);
      pushPair(24'hC3C3C3, 24'h3C3C3C);
      runFrame(32, -1);
   endtask

   task automatic test_truncate();
      pushPair(24'hF0F0F1, 24'h9ABCDE);
      pushPair(24'h13579B, 24'hEDCBA9);
      runFrame(16, -1);
      runFrame(32, -1);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_underflow();
      test_back_to_back();
      test_lrck_high_start();
      test_reset_midframe();
      test_truncate();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
